// File: rtl/digit_entry_pkg.sv
// Shared microwave package: digit-entry FSM encoding and BCD limits.
package digit_entry_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic is_digit(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_shift4.sv
// Four-digit BCD shift register: a new digit enters at sec_ones, min_tens drops out.
module bcd_shift4 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       shift,
  input  logic       clear,
  input  logic [3:0] din,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else if (clear) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else if (shift) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= din;
    end
  end

endmodule

// File: rtl/digit_entry.sv
// Keypad digit entry: debounces presses/releases and shifts accepted digits into an MM:SS time.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       all_off,
  input  logic       enablen,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       key_accept,
  output logic       time_valid
);

  localparam logic [8:0] DB_TARGET = 9'(DEBOUNCE_CYCLES);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] cap, cap_next;
  logic [8:0] cnt_inc;
  logic       accept;

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c >= 3'd4) ? 3'd4 : c + 3'd1;
  endfunction

  assign cnt_inc = {1'b0, cnt} + 9'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 8'd0;
      cap   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cap   <= cap_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cap_next   = cap;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!all_off && is_digit(D)) begin
          cap_next   = D;
          cnt_next   = 8'd1;
          state_next = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (all_off || !is_digit(D)) begin
          state_next = IDLE;
        end else if (D != cap) begin
          cap_next = D;
          cnt_next = 8'd1;
        end else begin
          cnt_next = cnt_inc[7:0];
          if (cnt_inc == DB_TARGET) begin
            accept     = 1'b1;
            state_next = HELD;
          end
        end
      end
      HELD: begin
        if (all_off) begin
          cnt_next   = 8'd1;
          state_next = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (!all_off) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc[7:0];
          if (cnt_inc == DB_TARGET) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Cancel parks on HELD while a key is still down so it cannot re-accept without a release.
    if (clear) begin
      accept     = 1'b0;
      state_next = all_off ? IDLE : HELD;
    end
    if (enablen) begin
      accept     = 1'b0;
      state_next = IDLE;
    end
  end

  bcd_shift4 u_shift (
    .clk      (clk),
    .resetn   (resetn),
    .shift    (accept),
    .clear    (clear),
    .din      (cap),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digit_count <= 3'd0;
      key_accept  <= 1'b0;
      time_valid  <= 1'b0;
    end else begin
      if (clear)       digit_count <= 3'd0;
      else if (accept) digit_count <= sat_inc(digit_count);
      key_accept <= accept;
      time_valid <= (sec_tens <= SEC_TENS_MAX) &&
                    ({min_tens, min_ones, sec_tens, sec_ones} != 16'd0);
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: directed scenarios plus random key activity against a run-length reference model.
module tb_digit_entry;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       all_off = 1'b1;
  logic       enablen = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       key_accept, time_valid;

  digit_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .D           (D),
    .all_off     (all_off),
    .enablen     (enablen),
    .clear       (clear),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .key_accept  (key_accept),
    .time_valid  (time_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;

  // Reference model: digits as an array (0 = min_tens), debounce as run lengths of samples.
  int m_dig[4];
  int m_cnt;
  bit m_ka, m_tv;
  bit m_ready;     // a fresh press may be accepted (key was released, or entry restarted)
  int m_prun;      // consecutive samples of the same pressed valid digit
  int m_rrun;      // consecutive released samples while waiting for release
  int m_key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_cnt = 0; m_ka = 0; m_tv = 0;
    m_ready = 1; m_prun = 0; m_rrun = 0; m_key = 0;
  endtask

  task automatic model_edge(input logic ao, input logic [3:0] d, input logic en, input logic clr);
    bit acc;
    acc = 0;
    m_tv = (m_dig[2] <= 5) && ((m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) != 0);
    if (!en && !ao && d <= 9) m_prun = (m_prun > 0 && int'(d) == m_key) ? m_prun + 1 : 1;
    else                      m_prun = 0;
    m_key = int'(d);
    if (!m_ready) begin
      m_rrun = ao ? m_rrun + 1 : 0;
      if (m_rrun == DB) begin m_ready = 1; m_rrun = 0; end
    end
    if (m_ready && m_prun == DB && !clr && !en) begin
      acc = 1;
      m_ready = 0; m_rrun = 0;
      m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = m_key;
      m_cnt = (m_cnt >= 4) ? 4 : m_cnt + 1;
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_cnt = 0; m_prun = 0; m_rrun = 0;
      m_ready = ao;
    end
    if (en) begin m_ready = 1; m_prun = 0; m_rrun = 0; end
    m_ka = acc;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".min_tens"}, min_tens, m_dig[0]);
    check({tag, ".min_ones"}, min_ones, m_dig[1]);
    check({tag, ".sec_tens"}, sec_tens, m_dig[2]);
    check({tag, ".sec_ones"}, sec_ones, m_dig[3]);
    check({tag, ".digit_count"}, digit_count, m_cnt);
    check({tag, ".key_accept"}, key_accept, m_ka);
    check({tag, ".time_valid"}, time_valid, m_tv);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check just after it.
  task automatic step(input logic ao, input logic [3:0] d, input logic en, input logic clr);
    all_off = ao; D = d; enablen = en; clear = clr;
    @(posedge clk);
    if (resetn) model_edge(ao, d, en, clr);
    else        model_reset();
    #1;
    if (key_accept === 1'b1) n_acc++;
    compare_all("cyc");
  endtask

  task automatic apply_reset(input int hold);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    repeat (hold) step(all_off, D, enablen, clear);
    resetn = 1'b1;
  endtask

  task automatic press_release(input logic [3:0] d);
    repeat (DB + 2) step(1'b0, d, 1'b0, 1'b0);
    repeat (DB + 2) step(1'b1, 4'd0, 1'b0, 1'b0);
  endtask

  int first;

  initial begin
    model_reset();
    @(posedge clk); #1;
    apply_reset(2);

    // Single clean press of 5
    n_acc = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'd5, 1'b0, 1'b0);
      if (key_accept === 1'b1 && first < 0) first = i + 1;
    end
    repeat (6) step(1'b1, 4'd0, 1'b0, 1'b0);
    check("p5.accepts", n_acc, 1);
    check("p5.latency", first, DB);
    check("p5.sec_ones", sec_ones, 5);
    check("p5.count", digit_count, 1);

    // Five keys saturate the count and keep the last four digits
    apply_reset(1);
    press_release(4'd1); press_release(4'd2); press_release(4'd3);
    press_release(4'd0); press_release(4'd7);
    check("t2307.time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h2307);
    check("t2307.count", digit_count, 4);
    check("t2307.valid", time_valid, 1);

    // Glitchy press: 3 bounces into 8
    apply_reset(1);
    n_acc = 0;
    repeat (2) step(1'b0, 4'd3, 1'b0, 1'b0);
    repeat (5) step(1'b0, 4'd8, 1'b0, 1'b0);
    repeat (6) step(1'b1, 4'd0, 1'b0, 1'b0);
    check("glitch.accepts", n_acc, 1);
    check("glitch.time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0008);

    // Clear on the acceptance edge of key 4
    apply_reset(1);
    press_release(4'd1);
    n_acc = 0;
    repeat (DB - 1) step(1'b0, 4'd4, 1'b0, 1'b0);
    step(1'b0, 4'd4, 1'b0, 1'b1);
    check("clr.key_accept", key_accept, 0);
    check("clr.time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("clr.count", digit_count, 0);
    repeat (6) step(1'b0, 4'd4, 1'b0, 1'b0);
    check("clr.no_reaccept", n_acc, 0);
    repeat (6) step(1'b1, 4'd0, 1'b0, 1'b0);
    press_release(4'd4);
    check("clr.after_release", n_acc, 1);
    check("clr.sec_ones", sec_ones, 4);

    // Reset mid-debounce with key 6 held
    apply_reset(1);
    repeat (2) step(1'b0, 4'd6, 1'b0, 1'b0);
    apply_reset(2);
    n_acc = 0; first = -1;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'd6, 1'b0, 1'b0);
      if (key_accept === 1'b1 && first < 0) first = i + 1;
    end
    check("rst6.latency", first, DB);
    check("rst6.accepts", n_acc, 1);
    check("rst6.sec_ones", sec_ones, 6);
    repeat (6) step(1'b1, 4'd0, 1'b0, 1'b0);

    // 00:99 is not a valid time; disabled entry ignores keys
    apply_reset(1);
    press_release(4'd9); press_release(4'd9);
    check("t99.time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0099);
    check("t99.valid", time_valid, 0);
    n_acc = 0;
    repeat (8) step(1'b0, 4'd2, 1'b1, 1'b0);
    repeat (6) step(1'b1, 4'd0, 1'b1, 1'b0);
    check("dis.accepts", n_acc, 0);
    check("dis.time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0099);
    check("dis.count", digit_count, 2);

    // Invalid codes are ignored
    n_acc = 0;
    repeat (8) step(1'b0, 4'd12, 1'b0, 1'b0);
    repeat (6) step(1'b1, 4'd0, 1'b0, 1'b0);
    check("bad.accepts", n_acc, 0);

    // Random key activity
    for (int s = 0; s < 400; s++) begin
      logic       r_ao, r_en, r_clr;
      logic [3:0] r_d;
      int         len;
      r_ao  = ($urandom_range(0, 2) == 0);
      r_d   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      r_en  = ($urandom_range(0, 19) == 0);
      r_clr = ($urandom_range(0, 29) == 0);
      len   = $urandom_range(1, 8);
      repeat (len) step(r_ao, r_d, r_en, r_clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4 (range 2..255): the number of consecutive identical samples required to accept a press or a release.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port D, input, 4 bits: the keypad digit code (0-9) from the keypad priority encoder.
REQ-005 The block SHALL have port all_off, input, 1 bit: high when no key is pressed.
REQ-006 The block SHALL have port enablen, input, 1 bit: active-low entry enable (low means entry is allowed).
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous cancel; zeroes the entered time.
REQ-008 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 bits each: the BCD MM:SS time being entered.
REQ-009 The block SHALL have port digit_count, output, 3 bits: the number of digits entered, saturating at 4.
REQ-010 The block SHALL have port key_accept, output, 1 bit: a one-cycle pulse on each accepted digit.
REQ-011 The block SHALL have port time_valid, output, 1 bit: registered; high when sec_tens <= 5 and the time is nonzero.

Function
REQ-012 The FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus an 8-bit stability counter cnt and a 4-bit captured digit cap.
REQ-013 IDLE: on all_off=0 and enablen=0, capture cap<=D, set cnt<=1 and go to PRESS_WAIT.
REQ-014 PRESS_WAIT: all_off=1 returns to IDLE; D!=cap recaptures cap<=D and sets cnt<=1; otherwise cnt increments.
REQ-015 PRESS_WAIT: on the edge where the increment would make cnt==DEBOUNCE_CYCLES, the digit is accepted and the FSM goes to HELD.
REQ-016 On acceptance, the time SHALL shift left by one BCD digit: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=cap; the old min_tens is discarded.
REQ-017 On acceptance, digit_count SHALL increment, saturating at 4.
REQ-018 key_accept SHALL be high for exactly the one cycle following the acceptance edge.
REQ-019 HELD: no further acceptance (no auto-repeat); all_off=1 sets cnt<=1 and goes to RELEASE_WAIT.
REQ-020 RELEASE_WAIT: all_off=0 returns to HELD; otherwise cnt increments, and on reaching DEBOUNCE_CYCLES the FSM goes to IDLE.
REQ-021 A digit change while in HELD SHALL NOT produce a new acceptance; the key must first be released.
REQ-022 enablen=1 SHALL force the FSM to IDLE on the next edge, abort any pending press and hold all digits; key_accept stays 0.
REQ-023 clear=1 SHALL zero all four digits and digit_count on the next edge, and the FSM SHALL go to HELD if all_off=0, else IDLE.
REQ-024 clear=1 SHALL take priority over an acceptance on the same edge: nothing is shifted in and key_accept stays 0.
REQ-025 Input codes D>9 SHALL be ignored: the FSM stays in or returns to IDLE.
REQ-026 time_valid SHALL be updated one cycle after the digits that determine it change.

Reset
REQ-027 resetn=0 SHALL immediately force the FSM to IDLE and zero cnt, cap, all digits, digit_count, key_accept and time_valid, including mid-debounce.
REQ-028 After resetn deasserts, a key already held SHALL be debounced from scratch: a full DEBOUNCE_CYCLES is required before acceptance.

Structure
REQ-029 The FSM state encoding and the BCD maximum constants (9, and 5 for tens-of-seconds) SHALL live in the shared microwave package.
REQ-030 One sub-module, bcd_shift4, SHALL hold the four-digit shift register with its shift and clear controls.
REQ-031 All other logic (FSM, counter, time_valid) SHALL be in digit_entry.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Press D=5 for 10 cycles, then release -> exactly one key_accept, 4 cycles after all_off falls; sec_ones=5, digit_count=1.
REQ-033 Enter 1,2,3,0,7 with clean presses and releases -> after the fifth key, time is 23:07, digit_count=4, time_valid=1.
REQ-034 Glitchy press (D=3 for 2 cycles, D=8 for 5 cycles) -> single acceptance of 8; 3 is never accepted.
REQ-035 Assert clear on the same edge as acceptance of key 4 -> all digits 0, digit_count=0, no key_accept; the held key does not re-accept until it is released.
REQ-036 Assert resetn low during PRESS_WAIT with key 6 held, then release reset -> outputs 0 during reset; after reset, key_accept occurs 4 cycles later with sec_ones=6.
REQ-037 Enter 9,9 giving 00:99 -> time_valid=0; with enablen=1, pressing 2 has no effect.
